// File: rtl/dbus_pkg.sv
// Shared types for the two-master data-bus arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dbus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } tsize_t;

  localparam logic TTYPE_READ  = 1'b0;
  localparam logic TTYPE_WRITE = 1'b1;

  // One-hot owner view of the arbitration state.
  function automatic logic [1:0] owner_onehot(input arb_state_t st);
    case (st)
      GRANT0:  return 2'b01;
      GRANT1:  return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/dbus_watchdog.sv
// Completion watchdog: counts granted cycles and flags expiry on the last allowed one.
// Latency: expire_o is combinational from the registered count (same cycle).
// Backpressure: none; TIMEOUT_CYCLES=0 disables it.
//   clk, rst_n : clock, async active-low reset
//   active_i   : a transaction is currently granted
//   done_i     : slave completion this cycle (suppresses expiry)
//   expire_o   : abort the current transaction this cycle
module dbus_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic active_i,
  input  logic done_i,
  output logic expire_o
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit          EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!EN || !active_i) begin
      cnt_d = '0;
    end else if (cnt_q != LAST) begin
      // Saturate so an owner that lingers after expiry cannot wrap the count.
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign expire_o = EN && active_i && !done_i && (cnt_q == LAST);

endmodule

// File: rtl/dbus_arbiter.sv
// Two-master dbus arbiter (core0 data port, debug SBA) with locking, round-robin and watchdog.
// Latency: grant registered, s_bstart rises 1 cycle after request; bdone same cycle as s_bdone.
// Backpressure: the losing master simply waits with bstart held; grants are never preempted.
//   m0_* : core0 data port      m1_* : debug system-bus-access engine
//   s_*  : forwarded slave side  halted : core0 in debug mode (m1 wins ties)
//   owner: one-hot current grant
module dbus_arbiter
  import dbus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              halted,
  input  logic              m0_bstart,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic              m0_ttype,
  input  logic [1:0]        m0_tsize,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_bdone,
  output logic              m0_err,
  input  logic              m1_bstart,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic              m1_ttype,
  input  logic [1:0]        m1_tsize,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_bdone,
  output logic              m1_err,
  output logic              s_bstart,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_wdata,
  output logic              s_ttype,
  output logic [1:0]        s_tsize,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic              s_bdone,
  output logic [1:0]        owner
);

  arb_state_t state_q, state_d;
  logic       last_q, last_d;   // index of the master that last completed
  logic       wd_expire;

  dbus_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wdog (
    .clk      (clk),
    .rst_n    (rst_n),
    .active_i (state_q != IDLE),
    .done_i   (s_bdone),
    .expire_o (wd_expire)
  );

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    s_bstart = 1'b0;
    s_addr   = '0;
    s_wdata  = '0;
    s_ttype  = 1'b0;
    s_tsize  = 2'b00;
    m0_rdata = '0;
    m0_bdone = 1'b0;
    m0_err   = 1'b0;
    m1_rdata = '0;
    m1_bdone = 1'b0;
    m1_err   = 1'b0;

    case (state_q)
      IDLE: begin
        if (m0_bstart && m1_bstart) begin
          // Debug access takes priority while the core is halted; otherwise alternate.
          state_d = (halted || !last_q) ? GRANT1 : GRANT0;
        end else if (m0_bstart) begin
          state_d = GRANT0;
        end else if (m1_bstart) begin
          state_d = GRANT1;
        end
      end
      GRANT0: begin
        s_bstart = m0_bstart;
        s_addr   = m0_addr;
        s_wdata  = m0_wdata;
        s_ttype  = m0_ttype;
        s_tsize  = m0_tsize;
        m0_rdata = s_rdata;
        if (!m0_bstart) begin
          // Owner withdrew: abort silently.
          state_d = IDLE;
        end else if (s_bdone || wd_expire) begin
          m0_bdone = 1'b1;
          m0_err   = !s_bdone;
          state_d  = IDLE;
          last_d   = 1'b0;
        end
      end
      GRANT1: begin
        s_bstart = m1_bstart;
        s_addr   = m1_addr;
        s_wdata  = m1_wdata;
        s_ttype  = m1_ttype;
        s_tsize  = m1_tsize;
        m1_rdata = s_rdata;
        if (!m1_bstart) begin
          state_d = IDLE;
        end else if (s_bdone || wd_expire) begin
          m1_bdone = 1'b1;
          m1_err   = !s_bdone;
          state_d  = IDLE;
          last_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  assign owner = owner_onehot(state_q);

endmodule

// File: tb/tb_dbus_arbiter.sv
// Randomized scoreboard bench for dbus_arbiter against a rule-level arbitration model.
// Latency: checks grant one cycle after the request, completion same cycle as s_bdone.
// Backpressure: each master holds its request until its own bdone.
module tb_dbus_arbiter;

  localparam int TO  = 8;
  localparam int NTX = 40;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        halted;
  logic        mb [2];
  logic [31:0] ma [2];
  logic [31:0] mw [2];
  logic        mt [2];
  logic [1:0]  mz [2];
  logic [31:0] m0_rdata, m1_rdata;
  logic        m0_bdone, m1_bdone, m0_err, m1_err;
  logic        s_bstart, s_ttype, s_bdone;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [1:0]  s_tsize, owner;
  wire  [1:0]  bd = {m1_bdone, m0_bdone};

  exp_t q0[$], q1[$];
  int   n_chk = 0, n_pass = 0;
  bit   mon_en = 0;
  bit   dn0 = 0, dn1 = 0;
  bit   last_m = 1;   // master that last completed; master 0 wins the first tie

  dbus_arbiter #(.TIMEOUT_CYCLES(TO), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .halted(halted),
    .m0_bstart(mb[0]), .m0_addr(ma[0]), .m0_wdata(mw[0]), .m0_ttype(mt[0]), .m0_tsize(mz[0]),
    .m0_rdata(m0_rdata), .m0_bdone(m0_bdone), .m0_err(m0_err),
    .m1_bstart(mb[1]), .m1_addr(ma[1]), .m1_wdata(mw[1]), .m1_ttype(mt[1]), .m1_tsize(mz[1]),
    .m1_rdata(m1_rdata), .m1_bdone(m1_bdone), .m1_err(m1_err),
    .s_bstart(s_bstart), .s_addr(s_addr), .s_wdata(s_wdata), .s_ttype(s_ttype), .s_tsize(s_tsize),
    .s_rdata(s_rdata), .s_bdone(s_bdone), .owner(owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Slave read data is a fixed function of the forwarded request, so it also exposes bad muxing.
  function automatic logic [31:0] resp(input logic [31:0] a, input logic [31:0] w,
                                       input logic t, input logic [1:0] z);
    return a ^ {w[15:0], w[31:16]} ^ {27'h0, t, 2'b00, z};
  endfunction

  // Slave model: completes after addr[11:8] granted cycles (0 = first granted cycle).
  int scnt = 0;
  initial begin
    s_bdone = 1'b0;
    s_rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      if (!rst_n || !s_bstart) begin
        scnt    = 0;
        s_bdone = 1'b0;
      end else begin
        s_bdone = (scnt == int'(s_addr[11:8]));
        s_rdata = resp(s_addr, s_wdata, s_ttype, s_tsize);
        scnt++;
      end
    end
  end

  task automatic drive(input int n);
    logic [31:0] a, w;
    logic        t;
    logic [1:0]  z;
    logic [3:0]  lat;
    bit          got;
    exp_t        e;
    for (int i = 0; i < NTX; i++) begin
      int gap;
      gap = $urandom_range(0, 3);
      if (gap != 0) begin
        mb[n] = 1'b0;
        repeat (gap) @(posedge clk);
        #1;
      end
      lat = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
      a = $urandom;
      a[11:8] = lat;
      w = $urandom;
      t = 1'($urandom_range(0, 1));
      z = 2'($urandom_range(0, 2));
      // Slave finishing on granted cycle index < TO completes normally; index TO-1 ties and wins.
      e.err   = (int'(lat) >= TO);
      e.rdata = resp(a, w, t, z);
      if (n == 0) q0.push_back(e);
      else        q1.push_back(e);
      ma[n] = a; mw[n] = w; mt[n] = t; mz[n] = z; mb[n] = 1'b1;
      got = 0;
      for (int c = 0; c < 60 && !got; c++) begin
        @(negedge clk);
        if (bd[n]) got = 1;
      end
      if (!got) chk("bdone_wait", 0, 1);
      @(posedge clk);
      #1;
    end
    mb[n] = 1'b0;
    if (n == 0) dn0 = 1;
    else        dn1 = 1;
  endtask

  // Monitor: rule-level arbitration model plus scoreboard pops on every bdone.
  initial begin
    logic [1:0] p_owner, p_req, p_bd, eo;
    logic       p_halt;
    bit         have_prev;
    int         idx;
    exp_t       e;
    have_prev = 0;
    p_owner = '0; p_req = '0; p_bd = '0; p_halt = 1'b0;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        have_prev = 0;
      end else begin
        if (have_prev) begin
          if (p_owner == 2'b00) begin
            if (p_req == 2'b00)      eo = 2'b00;
            else if (p_req == 2'b01) eo = 2'b01;
            else if (p_req == 2'b10) eo = 2'b10;
            else                     eo = (p_halt || last_m == 1'b0) ? 2'b10 : 2'b01;
          end else begin
            idx = p_owner[1] ? 1 : 0;
            eo  = (!p_req[idx] || p_bd[idx]) ? 2'b00 : p_owner;
          end
          chk("owner", owner, eo);
        end
        if (owner == 2'b01)
          chk("fwd0", {s_bstart, s_addr, s_wdata, s_ttype, s_tsize},
                      {mb[0], ma[0], mw[0], mt[0], mz[0]});
        else if (owner == 2'b10)
          chk("fwd1", {s_bstart, s_addr, s_wdata, s_ttype, s_tsize},
                      {mb[1], ma[1], mw[1], mt[1], mz[1]});
        else
          chk("idle_quiet", {s_bstart, bd, m0_rdata, m1_rdata}, 0);
        if (m0_bdone) begin
          chk("m0_owner", owner[0], 1);
          if (q0.size() == 0) chk("m0_unexpected", 1, 0);
          else begin
            e = q0.pop_front();
            chk("m0_err", m0_err, e.err);
            if (!e.err) chk("m0_rdata", m0_rdata, e.rdata);
          end
          last_m = 1'b0;
        end
        if (m1_bdone) begin
          chk("m1_owner", owner[1], 1);
          if (q1.size() == 0) chk("m1_unexpected", 1, 0);
          else begin
            e = q1.pop_front();
            chk("m1_err", m1_err, e.err);
            if (!e.err) chk("m1_rdata", m1_rdata, e.rdata);
          end
          last_m = 1'b1;
        end
        p_owner   = owner;
        p_req     = {mb[1], mb[0]};
        p_halt    = halted;
        p_bd      = bd;
        have_prev = 1;
      end
    end
  end

  initial begin
    bit got;
    rst_n  = 1'b0;
    halted = 1'b0;
    for (int i = 0; i < 2; i++) begin
      mb[i] = 1'b0; ma[i] = '0; mw[i] = '0; mt[i] = 1'b0; mz[i] = 2'b00;
    end
    #1;
    chk("reset_owner", owner, 0);
    chk("reset_s", {s_bstart, s_addr, s_wdata, s_ttype, s_tsize}, 0);
    chk("reset_m", {m0_bdone, m0_err, m1_bdone, m1_err, m0_rdata, m1_rdata}, 0);
    #22 rst_n = 1'b1;
    @(posedge clk);
    #1;
    mon_en = 1;

    fork
      drive(0);
      drive(1);
      begin
        while (!(dn0 && dn1)) begin
          @(posedge clk);
          #1;
          if ($urandom_range(0, 9) == 0) halted = ~halted;
        end
        halted = 1'b0;
      end
    join
    repeat (3) @(posedge clk);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);

    // Owner withdrawing mid-transaction: s_bstart falls with it, no bdone, then IDLE.
    #1;
    ma[0] = 32'h3000_0F00;
    mb[0] = 1'b1;
    got = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (owner == 2'b01) got = 1;
    end
    chk("abort_grant", got, 1);
    @(posedge clk);
    #1 mb[0] = 1'b0;
    @(negedge clk);
    chk("abort_drop", {s_bstart, m0_bdone, m0_err}, 0);
    @(negedge clk);
    chk("abort_idle", owner, 0);

    // Asynchronous reset while master 1 owns the bus.
    @(posedge clk);
    #1;
    ma[1] = 32'h3000_0F04;
    mb[1] = 1'b1;
    got = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (owner == 2'b10) got = 1;
    end
    chk("rst_grant", got, 1);
    @(posedge clk);
    #3;
    mon_en = 0;
    rst_n  = 1'b0;
    #1;
    chk("rst_owner", owner, 0);
    chk("rst_sbstart", s_bstart, 0);
    chk("rst_m1", {m1_bdone, m1_err}, 0);
    mb[1] = 1'b0;
    #10 rst_n = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/dbus_arbiter.md
Name: dbus_arbiter

Overview:
- Two-master, one-slave arbiter for the SoC data bus.
- Shares the dbus between the core0 data port (master 0) and the debug module system-bus-access engine (master 1, driven by sbcs/sbaddress0/sbdata0).
- Sits between the masters and the dbus address decoder.
- Provides registered grant, transaction locking until completion, round-robin fairness, halt-aware priority and a completion watchdog.

Parameters:
- TIMEOUT_CYCLES, 255: cycles a granted transaction may wait for s_bdone before being aborted with error; 0 disables the watchdog.
- ADDR_W, 32: address width.
- DATA_W, 32: data width.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- halted  in  1  core0 halted in debug mode
- m0_bstart  in  1  core request; held with attributes until m0_bdone
- m0_addr  in  ADDR_W  core address
- m0_wdata  in  DATA_W  core write data
- m0_ttype  in  1  core transfer type, 1=write, 0=read
- m0_tsize  in  2  core size, 0=byte, 1=half, 2=word
- m0_rdata  out  DATA_W  read data to core
- m0_bdone  out  1  one-cycle completion to core
- m0_err  out  1  qualifies m0_bdone; transaction aborted by watchdog
- m1_bstart, m1_addr, m1_wdata, m1_ttype, m1_tsize, m1_rdata, m1_bdone, m1_err: same as m0_*, for SBA
- s_bstart  out  1  request to slave side
- s_addr  out  ADDR_W  forwarded address
- s_wdata  out  DATA_W  forwarded write data
- s_ttype  out  1  forwarded transfer type
- s_tsize  out  2  forwarded size
- s_rdata  in  DATA_W  slave read data
- s_bdone  in  1  slave completion pulse
- owner  out  2  one-hot current grant, for debug and coverage

Behaviour:
- Clock and reset: single clock clk; asynchronous active-low reset rst_n.
- Reset values:
  - state=IDLE, owner=0, last=1 (master 0 wins the first tie), wdog=0.
  - s_bstart=0, all m*_bdone=0, m*_err=0, s_addr/s_wdata/s_ttype/s_tsize=0.
- States:
  - IDLE: no owner.
  - GRANT0 / GRANT1: owned by master 0 / master 1.
- IDLE decision, evaluated each cycle from m*_bstart:
  - Neither requesting: stay in IDLE.
  - One requesting: grant it.
  - Both requesting and halted=1: grant m1.
  - Both requesting and halted=0: grant the master != last (round-robin).
- Grant latency:
  - Transition is registered: owner and s_* outputs update on the clock edge.
  - s_bstart rises exactly 1 cycle after the winning m*_bstart is sampled in IDLE.
- GRANTn: s_* are combinationally muxed from master n. s_bstart = mn_bstart while owned.
- Completion:
  - On s_bdone=1 in GRANTn: mn_bdone=1 the same cycle, mn_rdata=s_rdata, mn_err=0.
  - Next edge: state to IDLE, last=n.
  - The non-owning master never sees bdone. Its rdata output is 0.
- Back-to-back: a master holding bstart after its own bdone re-enters arbitration in IDLE. Minimum 1 idle cycle between grants.
- Watchdog:
  - wdog increments each cycle in GRANTn without s_bdone and clears on leaving GRANTn.
  - When wdog==TIMEOUT_CYCLES-1 and no s_bdone: mn_bdone=1 and mn_err=1 for one cycle, then IDLE, last=n.
  - s_bdone in that same cycle wins: normal completion, err=0.
- Owner drops bstart mid-transaction: treated as abort. Return to IDLE next edge with no bdone. s_bstart falls with it.
- halted change mid-transaction: no effect until the next IDLE decision. Grants are never preempted.
- Reset mid-transaction: immediate return to reset values. No bdone is issued.
- tsize/ttype/addr: passed unmodified. No decode or alignment checks here; the decoder and slaves handle those.

Decomposition:
- Shared package dbus_pkg: arb_state_t enum {IDLE, GRANT0, GRANT1}, tsize_t enum {BYTE, HALF, WORD}, TTYPE_READ / TTYPE_WRITE constants.
- One sub-module, dbus_watchdog (counter plus expire flag, parameter TIMEOUT_CYCLES). Arbitration FSM and muxing stay in dbus_arbiter.

Test Plan:
- Core-only read:
  - Stimulus: m0 read at 0x3000000C; slave returns 0x000000A5 with s_bdone 3 cycles after s_bstart.
  - Required: s_bstart 1 cycle after m0_bstart; m0_bdone=1 with m0_rdata=0x000000A5 and m0_err=0; owner 01 then 00.
- Simultaneous requests, halted=0, after reset:
  - Stimulus: m0 writes 0x11, m1 writes 0x22, both to 0x30000000, both held.
  - Required: m0 served first, then m1. Grants alternate over 4 repeated rounds.
- Simultaneous requests, halted=1:
  - Required: m1 granted first regardless of last.
- Watchdog:
  - Stimulus: TIMEOUT_CYCLES=8, slave never asserts s_bdone.
  - Required: m0_bdone=1 and m0_err=1 on the 8th granted cycle; IDLE next cycle; a queued m1 is granted the cycle after.
- Lock and corner cases:
  - Stimulus: m1 asserts bstart while m0 owns the bus.
  - Required: no s_* change until m0_bdone; m1 is granted after the IDLE cycle.
  - Stimulus: s_bdone coinciding with watchdog expiry. Required: err=0.
- Reset mid-grant:
  - Stimulus: rst_n low while owner=10.
  - Required: owner=00, s_bstart=0, and no m1_bdone, all within the same cycle (asynchronous).
